// File: rtl/soup_ctrl_if.sv
// soup_ctrl_if: command, engine and transmitter signals around soup_ctrl.
// master = the controller side, slave = the surrounding rx/engine/tx blocks.
interface soup_ctrl_if #(
  parameter int NI = 400
);
  // from uart_rx
  logic            rx_break;
  logic            rx_run;
  logic [33:0]     rx_data;
  // to / from the soup engine
  logic            eng_start;
  logic            eng_abort;
  logic [31:0]     eng_seed;
  logic            eng_done;
  logic            eng_life;
  logic [NI-1:0]   eng_grid;
  // to uart_tx
  logic            tx_life;
  logic            tx_halt;
  logic            tx_break;
  logic [NI+31:0]  tx_data;
  // status
  logic            busy;

  modport master (
    input  rx_break, rx_run, rx_data, eng_done, eng_life, eng_grid,
    output eng_start, eng_abort, eng_seed, tx_life, tx_halt, tx_break,
           tx_data, busy
  );

  modport slave (
    output rx_break, rx_run, rx_data, eng_done, eng_life, eng_grid,
    input  eng_start, eng_abort, eng_seed, tx_life, tx_halt, tx_break,
           tx_data, busy
  );
endinterface

// File: rtl/soup_ctrl.sv
// soup_ctrl: sequences run commands into the Life soup engine and turns
// each engine result into one uart_tx request, then waits out the whole
// transmission. Sweep mode re-runs with seed+1 until a break arrives.
module soup_ctrl #(
  parameter int INIT   = 20,
  parameter int PERIOD = 434
) (
  input  logic      clk,
  input  logic      reset,
  soup_ctrl_if.master bus
);
  localparam int NI          = INIT * INIT;
  localparam int CHAR_CYCLES = 20 * PERIOD + 2;
  // Life report is the header plus the seed and one character per cell.
  localparam logic [31:0] HOLD_LIFE = 32'((NI + 33) * CHAR_CYCLES + 2);
  localparam logic [31:0] HOLD_HALT = 32'(CHAR_CYCLES + 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    RUN    = 3'd2,
    REPORT = 3'd3,
    HOLD   = 3'd4,
    NEXT   = 3'd5
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     seed_q;
  logic [1:0]      mode_q;
  logic [31:0]     hold_q;
  logic [31:0]     hold_dec;
  logic [31:0]     hold_load;
  logic [NI+31:0]  txd_q;
  logic            life_q;
  logic            txbrk_q;
  logic            abort_q;
  logic            sweep;

  // datapath strobes decided by the FSM
  logic            accept_run;
  logic            capture;
  logic            load_hold;
  logic            step_seed;

  // state-derived pulses
  logic            eng_start_c;
  logic            tx_life_c;
  logic            tx_halt_c;

  assign sweep    = (mode_q == 2'b01);
  // Saturating decrement; the HOLD exit looks at the post-decrement value
  // so a load of N keeps the controller in HOLD for N cycles (min 1).
  assign hold_dec = (hold_q == 32'd0) ? 32'd0 : hold_q - 32'd1;

  // Next state, datapath strobes and state-decoded pulses.
  always_comb begin
    state_nxt   = state;
    accept_run  = 1'b0;
    capture     = 1'b0;
    load_hold   = 1'b0;
    hold_load   = 32'd0;
    step_seed   = 1'b0;
    eng_start_c = 1'b0;
    tx_life_c   = 1'b0;
    tx_halt_c   = 1'b0;

    case (state)
      IDLE: begin
        // a break in the same cycle drops the run
        if (bus.rx_run && !bus.rx_break) begin
          accept_run = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        eng_start_c = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        if (bus.eng_done) begin
          capture   = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        load_hold = 1'b1;
        state_nxt = HOLD;
        if (life_q) begin
          tx_life_c = 1'b1;
          hold_load = HOLD_LIFE;
        end else if (!sweep) begin
          tx_halt_c = 1'b1;
          hold_load = HOLD_HALT;
        end
        // sweep halt: silent, hold_load stays 0 so HOLD lasts one cycle
      end
      HOLD: begin
        if (hold_dec == 32'd0)
          state_nxt = sweep ? NEXT : IDLE;
      end
      NEXT: begin
        step_seed = 1'b1;
        state_nxt = START;
      end
      default: state_nxt = IDLE;
    endcase

    // Break beats everything else outside IDLE, including a coincident
    // eng_done: nothing is captured and nothing further is requested.
    if (bus.rx_break && state != IDLE) begin
      state_nxt  = IDLE;
      capture    = 1'b0;
      load_hold  = 1'b0;
      step_seed  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Seed, mode, result capture, hold counter and registered abort pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q  <= '0;
      mode_q  <= '0;
      hold_q  <= '0;
      txd_q   <= '0;
      life_q  <= 1'b0;
      txbrk_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      txbrk_q <= bus.rx_break;
      abort_q <= bus.rx_break && (state == START || state == RUN);
      if (accept_run) begin
        seed_q <= bus.rx_data[31:0];
        mode_q <= bus.rx_data[33:32];
      end else if (step_seed) begin
        seed_q <= seed_q + 32'd1;
      end
      if (capture) begin
        txd_q  <= {seed_q, bus.eng_grid};
        life_q <= bus.eng_life;
      end
      if (load_hold)
        hold_q <= hold_load;
      else if (state == HOLD)
        hold_q <= hold_dec;
    end
  end

  assign bus.eng_start = eng_start_c;
  assign bus.eng_abort = abort_q;
  assign bus.eng_seed  = seed_q;
  assign bus.tx_life   = tx_life_c;
  assign bus.tx_halt   = tx_halt_c;
  assign bus.tx_break  = txbrk_q;
  assign bus.tx_data   = txd_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_soup_ctrl.sv
// tb_soup_ctrl: table of mode/result cases, directed corner sequences and a
// long random phase, all shadowed by a timeline reference model.
module tb_soup_ctrl;
  localparam int INIT   = 4;
  localparam int PERIOD = 2;
  localparam int NI     = 16;
  localparam int CHARC  = 20 * PERIOD + 2;        // 42
  localparam int H_LIFE = (NI + 33) * CHARC + 2;  // 2060
  localparam int H_HALT = CHARC + 2;              // 44

  logic clk   = 1'b0;
  logic reset = 1'b1;

  soup_ctrl_if #(.NI(NI)) bus();

  soup_ctrl #(.INIT(INIT), .PERIOD(PERIOD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // Reference model: tracks the expected timeline as cycle numbers.
  // A run accepted at k starts the engine at k+1; a result at u is
  // reported at u+1; the controller stays busy for max(H,1) cycles
  // after the report; sweep restarts the engine two cycles after that.
  // ---------------------------------------------------------------
  longint      cyc     = 0;
  logic        m_act   = 1'b0;
  logic        m_wait  = 1'b0;
  logic        m_sweep = 1'b0;
  logic        m_life  = 1'b0;
  logic        m_brk_d = 1'b0;
  logic        m_abt_d = 1'b0;
  logic [31:0] m_seed  = '0;
  logic [47:0] m_txd   = '0;
  longint      m_start = -1;
  longint      m_rep   = -1;
  longint      m_end   = -1;

  always @(posedge clk) begin
    logic [127:0] act, exp;
    longint h;
    #2;
    act = {bus.busy, bus.eng_start, bus.eng_abort, bus.tx_life, bus.tx_halt,
           bus.tx_break, bus.eng_seed, bus.tx_data};
    exp = {m_act, (m_act && m_wait && m_start == cyc), m_abt_d,
           (m_act && m_rep == cyc && m_life),
           (m_act && m_rep == cyc && !m_life && !m_sweep),
           m_brk_d, m_seed, m_txd};
    chk("model", act, exp);

    m_brk_d = 1'b0;
    m_abt_d = 1'b0;
    if (reset) begin
      m_act = 0; m_wait = 0; m_sweep = 0; m_life = 0;
      m_seed = '0; m_txd = '0; m_start = -1; m_rep = -1; m_end = -1;
    end else if (bus.rx_break) begin
      m_brk_d = 1'b1;
      m_abt_d = m_act && m_wait;
      m_act   = 0;
      m_wait  = 0;
    end else if (!m_act) begin
      if (bus.rx_run) begin
        m_act   = 1;
        m_wait  = 1;
        m_seed  = bus.rx_data[31:0];
        m_sweep = (bus.rx_data[33:32] == 2'b01);
        m_start = cyc + 1;
      end
    end else if (m_wait) begin
      if (bus.eng_done && cyc > m_start) begin
        m_wait = 0;
        m_txd  = {m_seed, bus.eng_grid};
        m_life = bus.eng_life;
        m_rep  = cyc + 1;
        h      = bus.eng_life ? H_LIFE : (m_sweep ? 0 : H_HALT);
        m_end  = m_rep + ((h == 0) ? 1 : h);
      end
    end else begin
      if (!m_sweep && cyc + 1 == m_end + 1) begin
        m_act = 0;
      end else if (m_sweep && cyc + 1 == m_end + 2) begin
        m_seed  = m_seed + 32'd1;
        m_wait  = 1;
        m_start = cyc + 1;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_run(input logic [33:0] d);
    bus.rx_run  = 1'b1;
    bus.rx_data = d;
    tick();
    bus.rx_run  = 1'b0;
  endtask

  task automatic pulse_done(input logic life, input logic [15:0] g);
    bus.eng_done = 1'b1;
    bus.eng_life = life;
    bus.eng_grid = g;
    tick();
    bus.eng_done = 1'b0;
  endtask

  task automatic send_break();
    bus.rx_break = 1'b1;
    tick();
    bus.rx_break = 1'b0;
    chk("break_txbrk", bus.tx_break, 1);
    chk("break_busy", bus.busy, 0);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        life;
    logic [31:0] seed;
    logic [15:0] grid;
    logic        e_life;
    logic        e_halt;
    int          e_cyc;   // REPORT -> busy low (single) or next eng_start (sweep)
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    int k;
    int starts;
    logic sw;
    logic [31:0] ws[3];

    bus.rx_break = 0; bus.rx_run = 0; bus.rx_data = '0;
    bus.eng_done = 0; bus.eng_life = 0; bus.eng_grid = '0;

    tbl[0] = '{2'b00, 1'b1, 32'hDEADBEEF, 16'hA5A5, 1'b1, 1'b0, H_LIFE + 1};
    tbl[1] = '{2'b00, 1'b0, 32'h12345678, 16'h0F0F, 1'b0, 1'b1, H_HALT + 1};
    tbl[2] = '{2'b01, 1'b1, 32'h00000100, 16'h1234, 1'b1, 1'b0, H_LIFE + 2};
    tbl[3] = '{2'b01, 1'b0, 32'h00000200, 16'hBEEF, 1'b0, 1'b0, 3};
    tbl[4] = '{2'b10, 1'b0, 32'h00000300, 16'h8001, 1'b0, 1'b1, H_HALT + 1};
    tbl[5] = '{2'b11, 1'b0, 32'h00000400, 16'h7FFE, 1'b0, 1'b1, H_HALT + 1};
    tbl[6] = '{2'b10, 1'b1, 32'h00000500, 16'hFFFF, 1'b1, 1'b0, H_LIFE + 1};
    tbl[7] = '{2'b11, 1'b1, 32'h00000600, 16'h0000, 1'b1, 1'b0, H_LIFE + 1};

    do_reset();
    chk("reset_outputs",
        {bus.busy, bus.eng_start, bus.eng_abort, bus.tx_life, bus.tx_halt,
         bus.tx_break, bus.eng_seed, bus.tx_data}, 0);

    // mode/result table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      pulse_run({tbl[i].mode, tbl[i].seed});
      chk("start", bus.eng_start, 1);
      chk("start_seed", bus.eng_seed, tbl[i].seed);
      chk("start_busy", bus.busy, 1);
      tick();
      pulse_done(tbl[i].life, tbl[i].grid);
      chk("tx_life", bus.tx_life, tbl[i].e_life);
      chk("tx_halt", bus.tx_halt, tbl[i].e_halt);
      chk("tx_data", bus.tx_data, {tbl[i].seed, tbl[i].grid});
      sw = (tbl[i].mode == 2'b01);
      n = 0;
      while ((sw ? !bus.eng_start : bus.busy) && n < 3000) begin
        tick();
        n++;
      end
      chk("report_to_end", n, tbl[i].e_cyc);
      if (sw) begin
        chk("sweep_seed", bus.eng_seed, tbl[i].seed + 32'd1);
        send_break();
      end
    end

    // sweep with seed wrap: halt, halt, life
    ws[0] = 32'hFFFFFFFE; ws[1] = 32'hFFFFFFFF; ws[2] = 32'h00000000;
    do_reset();
    pulse_run({2'b01, 32'hFFFFFFFE});
    tick();
    for (int j = 0; j < 3; j++) begin
      chk("wrap_seed", bus.eng_seed, ws[j]);
      pulse_done(j == 2, 16'h0100 + 16'(j));
      chk("wrap_tx_life", bus.tx_life, (j == 2));
      chk("wrap_tx_halt", bus.tx_halt, 0);
      if (j == 2) begin
        chk("wrap_tx_data", bus.tx_data, {32'h0, 16'h0102});
      end else begin
        k = 0;
        while (!bus.eng_start && k < 6) begin
          tick();
          k++;
        end
        chk("wrap_restart_cycles", k, 3);
        tick();
      end
    end
    send_break();

    // break during RUN of a sweep
    do_reset();
    pulse_run({2'b01, 32'h77});
    tick(); tick(); tick();
    bus.rx_break = 1'b1;
    tick();
    bus.rx_break = 1'b0;
    chk("brk_abort", bus.eng_abort, 1);
    chk("brk_txbrk", bus.tx_break, 1);
    chk("brk_busy", bus.busy, 0);
    tick();
    chk("brk_pulses_once", {bus.eng_abort, bus.tx_break}, 0);
    pulse_done(1'b1, 16'h5555);
    chk("brk_late_done", {bus.tx_life, bus.tx_halt, bus.busy}, 0);

    // run during HOLD is ignored; break+run in IDLE only breaks
    do_reset();
    pulse_run({2'b00, 32'h55});
    tick();
    pulse_done(1'b0, 16'h00F0);
    tick(); tick();
    pulse_run({2'b00, 32'h99});
    starts = 0;
    n = 0;
    while (bus.busy && n < 100) begin
      if (bus.eng_start) starts++;
      tick();
      n++;
    end
    chk("hold_run_ignored", starts, 0);
    chk("hold_seed_kept", bus.eng_seed, 32'h55);
    chk("hold_finished", bus.busy, 0);
    bus.rx_break = 1'b1;
    pulse_run({2'b00, 32'hAA});
    bus.rx_break = 1'b0;
    chk("idle_brkrun_txbrk", bus.tx_break, 1);
    chk("idle_brkrun_quiet", {bus.busy, bus.eng_start, bus.eng_abort}, 0);
    tick();
    chk("idle_brkrun_after", {bus.busy, bus.eng_start}, 0);

    // reset in HOLD, then a fresh run
    do_reset();
    pulse_run({2'b00, 32'hC0FFEE});
    tick();
    pulse_done(1'b1, 16'h1234);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hold_reset_outputs",
        {bus.busy, bus.eng_start, bus.eng_abort, bus.tx_life, bus.tx_halt,
         bus.tx_break, bus.eng_seed, bus.tx_data}, 0);
    tick();
    chk("hold_reset_no_pulse", {bus.tx_break, bus.eng_abort}, 0);
    pulse_run({2'b00, 32'h42});
    chk("fresh_start", bus.eng_start, 1);
    chk("fresh_seed", bus.eng_seed, 32'h42);
    send_break();

    // random phase, checked only by the model
    do_reset();
    for (int r = 0; r < 25000; r++) begin
      reset        = ($urandom_range(0, 2999) == 0);
      bus.rx_break = ($urandom_range(0, 299) == 0);
      bus.rx_run   = ($urandom_range(0, 7) == 0);
      bus.rx_data  = {(($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom)),
                      (($urandom_range(0, 3) == 0) ? 32'hFFFFFFFE : 32'($urandom))};
      bus.eng_done = ($urandom_range(0, 5) == 0);
      bus.eng_life = ($urandom_range(0, 4) == 0);
      bus.eng_grid = 16'($urandom);
      tick();
    end
    reset = 0; bus.rx_break = 0; bus.rx_run = 0; bus.eng_done = 0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soup_ctrl.md
# soup_ctrl

Sequencing controller between the UART command receiver, the Life soup engine and the UART report transmitter. It accepts run commands (seed + mode) from `uart_rx` and starts the engine. It captures each engine result and issues exactly one `life` or `halt` request to `uart_tx`, then holds off for the full transmission time. In sweep mode it steps the seed automatically until a break arrives.

## Interface
Parameters:
- `INIT`, 20, grid edge; NI = INIT*INIT
- `PERIOD`, 434, UART half-bit count, identical to the value given to `uart_tx`
- localparam `CHAR_CYCLES` = 20*PERIOD+2, cycles `uart_tx` spends per character

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `rx_break`  in  1  1-cycle break pulse from `uart_rx`
- `rx_run`  in  1  1-cycle run pulse from `uart_rx`
- `rx_data`  in  34  [31:0] seed, [33:32] mode; valid in the `rx_run` cycle
- `eng_start`  out  1  1-cycle engine start pulse
- `eng_abort`  out  1  1-cycle engine abort pulse
- `eng_seed`  out  32  seed; stable from `eng_start` until the result is reported
- `eng_done`  in  1  1-cycle result pulse
- `eng_life`  in  1  with `eng_done`: 1 = life result, 0 = halt result
- `eng_grid`  in  NI  grid snapshot, valid with `eng_done`
- `tx_life`  out  1  1-cycle life request to `uart_tx`
- `tx_halt`  out  1  1-cycle halt request to `uart_tx`
- `tx_break`  out  1  1-cycle abort to `uart_tx`
- `tx_data`  out  NI+32  [NI-1:0] grid, [NI+31:NI] seed
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, START, RUN, REPORT, HOLD, NEXT.
- IDLE: on `rx_run`, latch seed into `eng_seed` and mode into a mode register, then go to START. Mode 2'b01 = sweep. Every other mode value = single.
- START: pulse `eng_start` for one cycle, then go to RUN.
- RUN: wait for `eng_done`. On `eng_done`, latch `tx_data` = {`eng_seed`, `eng_grid`} and the result flag, then go to REPORT.
- REPORT: behaviour depends on mode and result.
  - Single mode, life result: pulse `tx_life`, load the hold counter with (NI+33)*CHAR_CYCLES+2.
  - Single mode, halt result: pulse `tx_halt`, load the hold counter with CHAR_CYCLES+2.
  - Sweep mode, life result: same as single mode.
  - Sweep mode, halt result: no tx request, load the hold counter with 0.
  - In all cases go to HOLD.
- HOLD: decrement the hold counter by 1 per cycle. At 0: single mode → IDLE; sweep mode → NEXT.
- NEXT: `eng_seed` <= `eng_seed`+1, mod 2^32 (0xFFFFFFFF wraps to 0), then go to START.
- `rx_run` outside IDLE is ignored. No queueing.
- `eng_done` outside RUN is ignored.
- `rx_break` in any non-IDLE state, same cycle:
  - Pulse `tx_break` next cycle.
  - Pulse `eng_abort` next cycle if the state was START or RUN.
  - Go to IDLE.
- `rx_break` in IDLE: pulse `tx_break` only.
- `rx_break` together with `rx_run`: break wins and the run is dropped.
- `rx_break` in the same cycle as `eng_done`: break wins and no report is issued.
- Hold counter width is 32 bits.

## Timing
- Reset: state IDLE; every pulse output 0; `eng_seed`, `tx_data`, the mode register and the hold counter all 0; `busy` 0.
- `rx_run` at cycle t → `eng_seed` valid and `busy`=1 at t+1 → `eng_start`=1 at t+1 (START state) → RUN at t+2.
- `eng_done` at cycle u → `tx_data` valid and `tx_life`/`tx_halt` high at u+1, for exactly 1 cycle.
- `tx_data` holds its value from u+1 until the next `eng_done` capture or reset.
- Hold length covers the `uart_tx` LIFE/HALT entry plus every SEND and DATA cycle, so `uart_tx` is back in IDLE before the next request.
- Sweep loop after a halt result: `eng_done` → next `eng_start` takes 4 cycles (REPORT, HOLD, NEXT, START).
- Break: `tx_break`/`eng_abort` high 1 cycle after `rx_break`; `busy`=0 on that same cycle.
- Reset mid-operation: back to the reset values on the next edge. No abort or break pulses are issued.

## Test plan
Bench parameters: INIT=4, PERIOD=2, so NI=16, CHAR_CYCLES=42.
1. Single run, life result. `rx_run` with `rx_data`=0x0_DEADBEEF; `eng_done` with `eng_life`=1 and grid 0xA5A5.
   - `eng_start` 1 cycle after `rx_run`, with `eng_seed`=0xDEADBEEF.
   - One `tx_life` pulse; `tx_data`={0xDEADBEEF,0xA5A5}.
   - `busy` falls 2060 cycles after REPORT.
2. Single run, halt result. `eng_done` with `eng_life`=0.
   - One `tx_halt` pulse, no `tx_life`.
   - IDLE 44 cycles after REPORT.
3. Sweep with seed wrap. Mode 01, seed 0xFFFFFFFE; engine returns halt, halt, life.
   - Successive `eng_seed` values 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
   - Only the third result produces `tx_life`, with seed 0 in `tx_data`.
4. Break during RUN of a sweep.
   - `eng_abort` and `tx_break` each pulse once; `busy`=0 one cycle later.
   - A later `eng_done` produces no tx pulse.
5. Run while busy and simultaneous events.
   - `rx_run` during HOLD → no new `eng_start`.
   - `rx_break`+`rx_run` in IDLE → `tx_break` only; `busy` stays 0.
6. Reset in HOLD.
   - All outputs return to 0 next cycle; no `tx_break` or `eng_abort`.
   - A fresh `rx_run` starts normally.
